// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control slice.
// Holds opcode/funct constants, ALU operation codes, FSM state codes and the
// one-hot instruction class produced by the decoder.
package mips_pkg;

    // Opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    // FSM state encodings
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // One-hot instruction class; all-zero means the instruction is illegal.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
    } ins_class_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Bus between the main control FSM and insfetch / datapath.
// master: the control FSM (drives ir, state, strobes, decode outputs, counters)
// slave : fetch/datapath side (drives ins and alu_zero)
interface mips_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ins;
    logic             alu_zero;
    logic [31:0]      ir;
    logic [2:0]       state;
    logic             pc_we;
    logic             npc_sel;
    logic             isJump;
    logic             reg_we;
    logic             reg_dst;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             ext_op;
    logic             mem_we;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ins, alu_zero,
        output ir, state, pc_we, npc_sel, isJump, reg_we, reg_dst, alu_src,
               alu_op, ext_op, mem_we, mem_to_reg, illegal, retired
    );

    modport slave (
        output ins, alu_zero,
        input  ir, state, pc_we, npc_sel, isJump, reg_we, reg_dst, alu_src,
               alu_op, ext_op, mem_we, mem_to_reg, illegal, retired
    );
endinterface

// File: rtl/mips_ins_decode.sv
// Combinational instruction classifier.
// Ports: opcode/funct in (fields of ir); cls out (one-hot class); illegal out
// (set when the opcode, or the R-type funct, is not supported).
module mips_ins_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ins_class_t cls,
    output logic       illegal
);
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                cls.addu = (funct == FN_ADDU);
                cls.subu = (funct == FN_SUBU);
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            default: cls = '0;
        endcase
        illegal = (cls == '0);
    end
endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Ports: clk, rst (synchronous, active high); bus (master side) carrying the
// fetched instruction in and the IR, state, strobes, decode-driven controls,
// sticky illegal flag and retired-instruction counter out.
// Every instruction retires in the single cycle where pc_we is high.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mips_mc_ctrl_if.master bus
);
    logic [2:0]       state_reg, state_next;
    logic [31:0]      ir_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] retired_reg;

    ins_class_t cls;
    logic       dec_illegal;

    logic pc_we_raw, npc_sel_raw, is_jump_raw, reg_we_raw, mem_we_raw;
    logic set_illegal;
    logic in_phase;

    // alu_zero is consumed by insfetch directly from the bus.
    logic unused_alu_zero;
    assign unused_alu_zero = bus.alu_zero;

    mips_ins_decode u_decode (
        .opcode  (ir_reg[31:26]),
        .funct   (ir_reg[5:0]),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // Next state and raw strobes
    always_comb begin
        state_next  = S_FETCH;
        pc_we_raw   = 1'b0;
        npc_sel_raw = 1'b0;
        is_jump_raw = 1'b0;
        reg_we_raw  = 1'b0;
        mem_we_raw  = 1'b0;
        set_illegal = 1'b0;
        case (state_reg)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) begin
                    // Retire as a nop with sequential PC.
                    set_illegal = 1'b1;
                    pc_we_raw   = 1'b1;
                end else if (cls.j) begin
                    is_jump_raw = 1'b1;
                    pc_we_raw   = 1'b1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.beq) begin
                    // Taken/not-taken is resolved in insfetch via alu_zero.
                    npc_sel_raw = 1'b1;
                    pc_we_raw   = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (cls.lw) begin
                    state_next = S_WB;
                end else if (cls.sw) begin
                    mem_we_raw = 1'b1;
                    pc_we_raw  = 1'b1;
                end
            end
            S_WB: begin
                reg_we_raw = 1'b1;
                pc_we_raw  = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Decode-driven controls are held constant over EXEC/MEM/WB.
    assign in_phase = (state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB);

    always_comb begin
        bus.alu_src    = in_phase & (cls.lw | cls.sw | cls.ori | cls.lui);
        bus.ext_op     = in_phase & (cls.lw | cls.sw);
        bus.reg_dst    = in_phase & (cls.addu | cls.subu);
        bus.mem_to_reg = in_phase & cls.lw;
        if (!in_phase)
            bus.alu_op = ALU_ADD;
        else if (cls.subu || cls.beq)
            bus.alu_op = ALU_SUB;
        else if (cls.ori)
            bus.alu_op = ALU_OR;
        else if (cls.lui)
            bus.alu_op = ALU_LUI;
        else
            bus.alu_op = ALU_ADD;
    end

    // Strobes are suppressed in any cycle where reset is asserted.
    assign bus.pc_we   = pc_we_raw   & ~rst;
    assign bus.npc_sel = npc_sel_raw & ~rst;
    assign bus.isJump  = is_jump_raw & ~rst;
    assign bus.reg_we  = reg_we_raw  & ~rst;
    assign bus.mem_we  = mem_we_raw  & ~rst;

    // Illegal becomes visible already in the DECODE cycle that detects it.
    assign bus.illegal = illegal_reg | (set_illegal & ~rst);
    assign bus.ir      = ir_reg;
    assign bus.state   = state_reg;
    assign bus.retired = retired_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            ir_reg      <= '0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH)
                ir_reg <= bus.ins;
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (pc_we_raw)
                retired_reg <= retired_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: the driver issues instructions on its own
// timing derived from the reference cycle counts and queues the expected retire
// record; a monitor pops one record per pc_we pulse and compares.
module tb_mips_mc_ctrl;
    localparam int TB_CNT_W = 4;   // narrow counter so wrap-around is exercised

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    mips_mc_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] word;
        int          cls;
        int          cyc;
        logic        ill;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Class codes: 0 addu 1 subu 2 ori 3 lui 4 lw 5 sw 6 beq 7 j 8 illegal
    function automatic int classify(input logic [31:0] w);
        case (w[31:26])
            6'b000000: begin
                if (w[5:0] == 6'b100001) return 0;
                if (w[5:0] == 6'b100011) return 1;
                return 8;
            end
            6'b001101: return 2;
            6'b001111: return 3;
            6'b100011: return 4;
            6'b101011: return 5;
            6'b000100: return 6;
            6'b000010: return 7;
            default:   return 8;
        endcase
    endfunction

    function automatic int cpi_of(input int c);
        if (c == 7 || c == 8) return 2;
        if (c == 6) return 3;
        if (c == 4) return 5;
        return 4;
    endfunction

    function automatic logic [2:0] retire_state(input int c);
        if (c == 7 || c == 8) return 3'd1;
        if (c == 6) return 3'd2;
        if (c == 5) return 3'd3;
        return 3'd4;
    endfunction

    // {isJump, npc_sel, mem_we, reg_we} in the retiring cycle
    function automatic logic [3:0] exp_strobes(input int c);
        if (c == 7) return 4'b1000;
        if (c == 6) return 4'b0100;
        if (c == 5) return 4'b0010;
        if (c == 8) return 4'b0000;
        return 4'b0001;
    endfunction

    // {reg_dst, mem_to_reg, alu_src, ext_op, alu_op[1:0]} and the bits that matter
    function automatic logic [5:0] exp_ctrl(input int c);
        case (c)
            0: return 6'b100000;
            1: return 6'b100001;
            2: return 6'b001010;
            3: return 6'b001011;
            4: return 6'b011100;
            5: return 6'b001100;
            6: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] ctrl_mask(input int c);
        case (c)
            0, 1, 3: return 6'b111011;
            2, 4, 5: return 6'b111111;
            6:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: begin w[31:26] = 6'b000000; w[5:0] = 6'b100001; end
            1: begin w[31:26] = 6'b000000; w[5:0] = 6'b100011; end
            2: w[31:26] = 6'b001101;
            3: w[31:26] = 6'b001111;
            4: w[31:26] = 6'b100011;
            5: w[31:26] = 6'b101011;
            6: w[31:26] = 6'b000100;
            7: w[31:26] = 6'b000010;
            8: begin
                for (int t = 0; t < 16 && classify(w) != 8; t++) w[31:26] = 6'($urandom);
                if (classify(w) != 8) w[31:26] = 6'b111111;
            end
            default: begin
                w[31:26] = 6'b000000;
                if (w[5:0] == 6'b100001 || w[5:0] == 6'b100011) w[5:0] = 6'b000000;
            end
        endcase
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver / reference model ----------------
    int   drv_cyc = 0;     // cycles since last reset release
    int   ret_cnt = 0;     // instructions retired since last reset
    logic sticky  = 1'b0;  // model of the sticky illegal flag

    task automatic issue(input logic [31:0] w);
        rec_t r;
        int   c;
        c = classify(w);
        if (c == 8) sticky = 1'b1;
        r.word = w;
        r.cls  = c;
        r.cyc  = drv_cyc + cpi_of(c) - 1;
        r.ill  = sticky;
        sb.push_back(r);
        drv_cyc += cpi_of(c);
        ret_cnt++;
        bus.ins = w;
        bus.alu_zero = 1'($urandom);
        repeat (cpi_of(c) - 1) begin
            @(posedge clk); #1;
            bus.ins = $urandom;          // must be ignored outside FETCH
            bus.alu_zero = 1'($urandom);
        end
        @(posedge clk); #1;
    endtask

    // lw aborted by reset during its EXEC cycle
    task automatic abort_lw();
        bus.ins = 32'h8C220004;
        @(posedge clk); #1;
        bus.ins = $urandom;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drv_cyc = 0;
        ret_cnt = 0;
        sticky  = 1'b0;
    endtask

    initial begin
        bus.ins = '0;
        bus.alu_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        issue(32'h00221821);   // addu
        issue(32'h8C220004);   // lw
        issue(32'hAC220008);   // sw
        issue(32'h10220003);   // beq
        issue(32'h08000010);   // j
        issue(32'hFC000000);   // illegal opcode
        issue(32'h34220005);   // ori, illegal stays set
        abort_lw();
        for (int i = 0; i < 60; i++) issue(rand_ins());
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d retirements never seen, required 0", sb.size());
        end
        chk("final_retired", 64'(bus.retired), 64'(ret_cnt[TB_CNT_W-1:0]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        int   mcyc;
        logic after_rst;
        logic [TB_CNT_W-1:0] exp_ret;
        rec_t r;
        mcyc = 0;
        after_rst = 1'b0;
        exp_ret = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_strobes",
                    {59'd0, bus.pc_we, bus.npc_sel, bus.isJump, bus.reg_we, bus.mem_we}, 64'd0);
                mcyc = 0;
                exp_ret = '0;
                after_rst = 1'b1;
            end else begin
                if (after_rst) begin
                    chk("reset_state", {bus.state, bus.ir, bus.retired, bus.illegal}, 64'd0);
                    after_rst = 1'b0;
                end
                if (bus.pc_we) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL retire_unexpected: pc_we at cycle %0d, required none", mcyc);
                    end else begin
                        r = sb.pop_front();
                        $display("retire ir=%h cls=%0d cycle=%0d retired=%0d", bus.ir, r.cls, mcyc, bus.retired);
                        chk("retire_cycle", 64'(mcyc), 64'(r.cyc));
                        chk("retire_state", 64'(bus.state), 64'(retire_state(r.cls)));
                        chk("ir", 64'(bus.ir), 64'(r.word));
                        chk("strobes", 64'({bus.isJump, bus.npc_sel, bus.mem_we, bus.reg_we}),
                            64'(exp_strobes(r.cls)));
                        chk("ctrl", 64'({bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.ext_op, bus.alu_op}
                                         & ctrl_mask(r.cls)),
                            64'(exp_ctrl(r.cls) & ctrl_mask(r.cls)));
                        chk("illegal", 64'(bus.illegal), 64'(r.ill));
                        chk("retired", 64'(bus.retired), 64'(exp_ret));
                        exp_ret = exp_ret + 1'b1;
                    end
                end else begin
                    chk("spurious_strobe", 64'({bus.isJump, bus.npc_sel, bus.mem_we, bus.reg_we}), 64'd0);
                end
                mcyc++;
            end
        end
    end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle main control FSM that sits directly downstream of insfetch.
- Latches the fetched instruction (`im_out_ins`) into an internal IR and decodes it.
- Steps through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control strobes, including `npc_sel`, `isJump` and `pc_we` back into insfetch.
- Retires exactly one instruction per pass and keeps a retired-instruction counter for bring-up.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ins  in  32  instruction from insfetch (`im_out_ins`); sampled only in FETCH.
- alu_zero  in  1  ALU zero flag; passed through to insfetch, not used internally.
- ir  out  32  latched instruction register.
- state  out  3  current FSM state encoding.
- pc_we  out  1  PC update strobe to insfetch.
- npc_sel  out  1  branch select to insfetch (beq).
- isJump  out  1  jump select to insfetch (j).
- reg_we  out  1  register-file write enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- alu_src  out  1  1 = extended imm16, 0 = rt.
- alu_op  out  2  00 add, 01 sub, 10 or, 11 lui-shift.
- ext_op  out  1  1 = sign-extend, 0 = zero-extend.
- mem_we  out  1  data-memory write enable.
- mem_to_reg  out  1  1 = write-back from memory.
- illegal  out  1  sticky unknown-opcode flag.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset:
  - state = FETCH, ir = 0, retired = 0, illegal = 0.
  - All strobes (pc_we, npc_sel, isJump, reg_we, mem_we) = 0.
- Supported opcodes:
  - R-type 000000 with funct 100001 (addu) or 100011 (subu).
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 go to FETCH next cycle with no strobes.
- FETCH: ir <= ins; go to DECODE. No strobes.
- DECODE:
  - j: assert isJump=1 and pc_we=1 for this cycle, retire, go to FETCH.
  - Unknown opcode or R-type funct: set illegal=1, assert pc_we=1 (sequential PC+4), retire as nop, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - beq: npc_sel=1, pc_we=1, alu_op=01, retire, go to FETCH. Taken/not-taken is resolved by insfetch from alu_zero.
  - lw/sw: alu_src=1, ext_op=1, alu_op=00, go to MEM.
  - R-type, ori, lui: go to WB.
- MEM:
  - lw: go to WB, no strobes.
  - sw: mem_we=1, pc_we=1, retire, go to FETCH.
- WB: reg_we=1 and pc_we=1, retire, go to FETCH.
  - R-type: reg_dst=1.
  - lw: mem_to_reg=1.
  - ori: alu_src=1, ext_op=0.
  - lui: alu_src=1, alu_op=11.
- Decode-driven outputs (alu_op, alu_src, ext_op, reg_dst, mem_to_reg) are combinational from ir and state and hold their values across EXEC/MEM/WB.
- Strobes are combinational from state and ir. Each is high for exactly one cycle per instruction.
- Cycles per instruction: j and illegal 2; beq 3; sw, R-type, ori, lui 4; lw 5.
- pc_we fires exactly once per instruction, always in the retiring cycle. retired increments in that same cycle, so the new value is visible next cycle.
- retired wraps modulo 2^CNT_W with no flag.
- illegal clears only on rst.
- rst asserted mid-instruction: next state is FETCH, counters clear, and no strobe is asserted in the reset cycle. rst has priority over all transitions.
- ins is ignored outside FETCH, so a changing fetch output mid-instruction has no effect.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J;
  - funct constants FN_ADDU, FN_SUBU;
  - ALU op codes ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI;
  - state encodings S_FETCH … S_WB.
- One sub-module, mips_ins_decode: purely combinational, maps ir to a one-hot instruction class plus an illegal bit.
- The FSM, strobes and counters stay in mips_mc_ctrl.

Test Plan:
- Reset, then addu (0x00221821): states 0→1→2→4→0; reg_we=1 and reg_dst=1 only in WB; pc_we pulses once; retired=1 after 4 cycles.
- lw (0x8C220004) then sw (0xAC220008):
  - lw takes 5 cycles with mem_to_reg=1 in WB.
  - sw takes 4 cycles with mem_we=1 in MEM and no reg_we.
  - retired=2 after 9 cycles.
- beq (0x10220003): npc_sel=1 and pc_we=1 in EXEC only; alu_op=01; back to FETCH in cycle 4; alu_zero toggled either way leaves the FSM timing unchanged.
- j (0x08000010): isJump=1 and pc_we=1 in DECODE; 2-cycle instruction; no reg_we or mem_we at any point.
- Opcode 0x3F (0xFC000000): illegal rises in DECODE and stays 1 through a following valid ori (0x34220005); pc_we pulses once; retired increments.
- rst pulsed during EXEC of lw: the next cycle is FETCH with retired=0 and illegal=0; mem_we and reg_we never assert for the aborted lw.
